// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: default parameter values,
// FSM state encoding and the width of the optional period counter.
package freq_meter_pkg;

  // Default gate window: 1 s at a 50 MHz system clock.
  localparam int FM_GATE_CYCLES_DEF  = 50_000_000;
  localparam int FM_CNT_W_DEF        = 24;
  localparam int FM_SYNC_STAGES_DEF  = 2;

  // Width of the period-measurement counter and its result.
  localparam int PERIOD_W = 32;

  // Measurement FSM states (IDLE, GATE, LATCH).
  typedef logic [1:0] fm_state_t;
  localparam fm_state_t ST_IDLE  = 2'd0;
  localparam fm_state_t ST_GATE  = 2'd1;
  localparam fm_state_t ST_LATCH = 2'd2;

endpackage

// File: rtl/edge_sync_detect.sv
// Brings an asynchronous input into the clk domain through a SYNC_STAGES
// flop chain and emits a one-cycle pulse on each synchronized rising edge.
// SYNC_STAGES must be at least 2.
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one previous-sample flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge: last stage high while the previous sample was low.
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a gate
// window of GATE_CYCLES clk cycles and publishes one result per window.
// FSM: IDLE -> GATE (GATE_CYCLES cycles) -> LATCH (one cycle, result out).
// Dropping en during GATE aborts the window without touching the result.
// Optional feature macro: FREQ_METER_PERIOD_MEAS_EN adds a free-running
// edge-to-edge period measurement; without it the period outputs are 0.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = FM_GATE_CYCLES_DEF,
  parameter int CNT_W       = FM_CNT_W_DEF,
  parameter int SYNC_STAGES = FM_SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                sig_in,
  output logic [CNT_W-1:0]    freq_count,
  output logic                valid,
  output logic                overflow,
  output logic                busy,
  output logic [PERIOD_W-1:0] period_cycles,
  output logic                period_valid
);

  // GATE_CYCLES >= 4 keeps this at least 2 bits; the last index always fits.
  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic sig_edge;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync_detect (
    .clk       (clk),
    .reset     (reset),
    .async_in  (sig_in),
    .edge_pulse(sig_edge)
  );

  fm_state_t         state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              overflow_q, overflow_d;
  logic              valid_q, valid_d;
  logic              edge_sat;

  assign edge_sat = (edge_cnt_q == {CNT_W{1'b1}});

  // Next-state logic: window timing, saturating edge count, result capture.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        if (en) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (!en) begin
          // Abort: previous result and overflow stay as they are.
          state_d = ST_IDLE;
        end else begin
          if (sig_edge) begin
            if (edge_sat) ovf_d = 1'b1;
            else          edge_cnt_d = edge_cnt_q + 1'b1;
          end
          if (gate_cnt_q == GATE_LAST) begin
            // Result is registered on entry to LATCH so it appears together
            // with valid; the edge of this final cycle is already included.
            state_d    = ST_LATCH;
            freq_d     = edge_cnt_d;
            overflow_d = ovf_d;
            valid_d    = 1'b1;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        // Dead cycle: an edge seen here is not counted anywhere.
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        state_d    = en ? ST_GATE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Measurement state and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_count = freq_q;
  assign overflow   = overflow_q;
  assign valid      = valid_q;
  assign busy       = (state_q == ST_GATE);

`ifdef FREQ_METER_PERIOD_MEAS_EN
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0] per_out_q, per_out_d;
  logic                seen_q, seen_d;
  logic                pv_q, pv_d;

  // Cycles since the last edge (saturating); publish it on every edge
  // except the first one after reset, which has no reference edge.
  always_comb begin
    per_cnt_d = (per_cnt_q != {PERIOD_W{1'b1}}) ? per_cnt_q + 1'b1 : per_cnt_q;
    per_out_d = per_out_q;
    seen_d    = seen_q;
    pv_d      = 1'b0;
    if (sig_edge) begin
      per_cnt_d = PERIOD_W'(1);
      seen_d    = 1'b1;
      if (seen_q) begin
        per_out_d = per_cnt_q;
        pv_d      = 1'b1;
      end
    end
  end

  // Period measurement registers, independent of en and the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_q <= '0;
      per_out_q <= '0;
      seen_q    <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      per_out_q <= per_out_d;
      seen_q    <= seen_d;
      pv_q      <= pv_d;
    end
  end

  assign period_cycles = per_out_q;
  assign period_valid  = pv_q;
`else
  assign period_cycles = '0;
  assign period_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with GATE_CYCLES=100, CNT_W=4, SYNC_STAGES=2.
// A reference model works on cycle indices: each rising transition of sig_in
// becomes an edge timestamp two cycles later, and a window result is the
// number of timestamps inside [window_start, window_start+99].
module tb_freq_meter;

  localparam int G  = 100;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic en;
  logic sig_in;
  logic [CW-1:0] freq_count;
  logic          valid;
  logic          overflow;
  logic          busy;
  logic [31:0]   period_cycles;
  logic          period_valid;

  always #5 clk = ~clk;

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sig_in       (sig_in),
    .freq_count   (freq_count),
    .valid        (valid),
    .overflow     (overflow),
    .busy         (busy),
    .period_cycles(period_cycles),
    .period_valid (period_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / check helper ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- sig_in generator ----------------
  // per > 0: square wave rising once every per cycles; 0: held low;
  // < 0: random bit each cycle.
  int per = 0;
  int ph  = 0;
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (per < 0) begin
        sig_in = 1'($urandom_range(0, 1));
      end else if (per == 0) begin
        sig_in = 1'b0;
      end else begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        sig_in = (ph < per / 2);
      end
    end
  end

  // ---------------- reference model + compare ----------------
  int  exp_q[$];      // edge timestamps for window counting
  int  pend_q[$];     // edge timestamps for the period path
  int  mstat = 0;     // 0 idle, 1 in window, 2 result cycle
  int  ws = 0;
  int  exp_freq = 0;
  bit  exp_ovf = 1'b0;
  longint exp_pc = 0;
  bit  exp_pv = 1'b0;
  int  last_e = -1;
  bit  en_prev = 1'b0;
  bit  sig_prev = 1'b0;

  always @(negedge clk) begin
    int i;
    int cnt;
    if (!reset) begin
      mstat = 0; exp_freq = 0; exp_ovf = 1'b0; exp_pc = 0; exp_pv = 1'b0;
      last_e = -1; exp_q.delete(); pend_q.delete();
      en_prev = 1'b0; sig_prev = 1'b0;
    end else begin
      i = cyc;
      exp_pv = 1'b0;
      case (mstat)
        0: if (en_prev) begin
          mstat = 1; ws = i;
          while (exp_q.size() > 0 && exp_q[0] < ws) void'(exp_q.pop_front());
        end
        1: if (!en_prev) begin
          mstat = 0;
        end else if (i - 1 - ws == G - 1) begin
          mstat = 2;
          cnt = 0;
          foreach (exp_q[k]) if (exp_q[k] >= ws && exp_q[k] <= i - 1) cnt++;
          exp_freq = (cnt > CMAX) ? CMAX : cnt;
          exp_ovf  = (cnt > CMAX);
        end
        default: if (en_prev) begin
          mstat = 1; ws = i;
          while (exp_q.size() > 0 && exp_q[0] < ws) void'(exp_q.pop_front());
        end else begin
          mstat = 0;
        end
      endcase
      if (pend_q.size() > 0 && pend_q[0] == i - 1) begin
        void'(pend_q.pop_front());
`ifdef FREQ_METER_PERIOD_MEAS_EN
        if (last_e >= 0) begin
          exp_pv = 1'b1;
          exp_pc = i - 1 - last_e;
        end
`endif
        last_e = i - 1;
      end
      if (sig_in && !sig_prev) begin
        exp_q.push_back(i + 2);
        pend_q.push_back(i + 2);
      end
      en_prev  = en;
      sig_prev = sig_in;
      if (chk_on) begin
        check("busy",          busy,          (mstat == 1));
        check("valid",         valid,         (mstat == 2));
        check("freq_count",    freq_count,    exp_freq);
        check("overflow",      overflow,      exp_ovf);
        check("period_cycles", period_cycles, exp_pc);
        check("period_valid",  period_valid,  exp_pv);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit en_v);
    @(posedge clk);
    #1;
    en = en_v;
  endtask

  // Cycles from the calling cycle to the next valid pulse (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (valid) break;
      n++;
      if (n > 400) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_valid: no valid within 400 cycles (cycle %0d)", cyc);
        break;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    en    = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_freq_count", freq_count, 0);
    check("rst_valid",      valid,      0);
    check("rst_busy",       busy,       0);
    check("rst_overflow",   overflow,   0);
    check("rst_period",     period_cycles, 0);
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_on = 1'b1;

    // Edges every 10 cycles: 10 per window, one result every 101 cycles.
    per = 10;
    repeat (5) step(1'b0);
    step(1'b1);
    wait_valid(n);
    check("first_latency", n, 101);
    check("p10_freq", freq_count, 10);
    wait_valid(n);
    check("result_period", n, 100);
    check("p10_freq2", freq_count, 10);
    check("p10_ovf",   overflow,   0);

    // Input held low: zero result.
    per = 0;
    wait_valid(n);
    wait_valid(n);
    check("zero_freq", freq_count, 0);
    check("zero_ovf",  overflow,   0);

    // Edges every 2 cycles saturate the 4-bit counter.
    per = 2;
    wait_valid(n);
    wait_valid(n);
    check("sat_freq", freq_count, 15);
    check("sat_ovf",  overflow,   1);

    // 5 edges per window: overflow clears.
    per = 20;
    wait_valid(n);
    wait_valid(n);
    check("p20_freq", freq_count, 5);
    check("p20_ovf",  overflow,   0);

    // Abort mid-window: no result, old value kept, fresh window afterwards.
    per = 10;
    wait_valid(n);
    wait_valid(n);
    check("pre_abort_freq", freq_count, 10);
    repeat (50) step(1'b1);
    repeat (20) step(1'b0);
    check("abort_busy",  busy,       0);
    check("abort_freq",  freq_count, 10);
    step(1'b1);
    wait_valid(n);
    check("abort_restart_latency", n, 101);
    check("abort_restart_freq",    freq_count, 10);

    // Asynchronous reset mid-window.
    repeat (30) step(1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_freq",  freq_count, 0);
    check("async_rst_busy",  busy,       0);
    check("async_rst_valid", valid,      0);
    check("async_rst_ovf",   overflow,   0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_valid(n);
    check("post_rst_latency", n, 101);

    // Randomized segments: mixed rates, random-bit input, short en drops.
    for (int w = 0; w < 12; w++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      per = 0;
      else if (r == 1) per = -1;
      else             per = $urandom_range(2, 25);
      repeat ($urandom_range(80, 250)) step($urandom_range(0, 99) >= 3);
    end
    step(1'b1);

    // Period measurement with edges every 7 cycles.
    per = 7;
    repeat (40) step(1'b1);
`ifdef FREQ_METER_PERIOD_MEAS_EN
    n = 0;
    while (!period_valid && n < 30) begin @(negedge clk); n++; end
    check("period_seen", period_valid, 1);
    check("period_lit",  period_cycles, 7);
    n = 0;
    @(negedge clk);
    while (!period_valid && n < 30) begin @(negedge clk); n++; end
    check("period_spacing", n + 1, 7);
`else
    check("period_tied_cycles", period_cycles, 0);
    check("period_tied_valid",  period_valid,  0);
`endif
    repeat (5) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
